// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - EX stage scheduler encodings and state type
package ex_pkg;

   // functional-unit class of a decoded op
   localparam logic [1:0] EX_CLS_ALU = 2'b00;
   localparam logic [1:0] EX_CLS_MUL = 2'b01;
   localparam logic [1:0] EX_CLS_DIV = 2'b10;
   localparam logic [1:0] EX_CLS_ILL = 2'b11;

   // ALU op codes
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   // multiplier op codes
   localparam logic [1:0] MUL_MUL    = 2'b00;
   localparam logic [1:0] MUL_MULH   = 2'b01;
   localparam logic [1:0] MUL_MULHSU = 2'b10;
   localparam logic [1:0] MUL_MULHU  = 2'b11;

   // divider op codes
   localparam logic [1:0] DIV_DIV  = 2'b00;
   localparam logic [1:0] DIV_DIVU = 2'b01;
   localparam logic [1:0] DIV_REM  = 2'b10;
   localparam logic [1:0] DIV_REMU = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ALU_EX   = 3'd1,
      ST_MUL_WAIT = 3'd2,
      ST_DIV_WAIT = 3'd3,
      ST_RESP     = 3'd4
   } ex_state_t;

endpackage

// File: rtl/ex_lat_counter.sv
// rtl/ex_lat_counter.sv - loadable non-wrapping down-counter with zero flag
module ex_lat_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // load has priority; decrement saturates at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/ex_fu_scheduler.sv
// rtl/ex_fu_scheduler.sv - EX stage single-issue FU scheduler; EX_SCHED_DIV_EN enables divider sequencing
module ex_fu_scheduler
   import ex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_class,
   input  logic [3:0]      in_aluctl,
   input  logic [1:0]      in_mulctl,
   input  logic [1:0]      in_divctl,
   input  logic [4:0]      in_rd,
   output logic [3:0]      alu_ctl,
   input  logic [XLEN-1:0] alu_result,
   output logic            mul_start,
   output logic [1:0]      mul_ctl,
   input  logic [XLEN-1:0] mul_result,
   output logic            div_start,
   output logic [1:0]      div_ctl,
   input  logic            div_done,
   input  logic [XLEN-1:0] div_result,
   output logic            div_abort,
   input  logic            flush,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] res_data,
   output logic [4:0]      res_rd,
   output logic            res_illegal,
   output logic            busy
);

   localparam int CW = $clog2(MUL_LAT + 1);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);

   ex_state_t state;
   ex_state_t acc_state;
   logic      acc_illegal;
   logic      accept;
   logic      cnt_zero;

   // ready in IDLE, or in RESP when the held result is consumed this cycle
   assign in_ready = ~rst & ~flush & ((state == ST_IDLE) | ((state == ST_RESP) & res_ready));
   assign accept   = in_ready & in_valid;

   // class decode: destination state for an accepted op
   always_comb begin
      acc_state   = ST_RESP;
      acc_illegal = 1'b1;
      case (in_class)
         EX_CLS_ALU: begin
            acc_state   = ST_ALU_EX;
            acc_illegal = 1'b0;
         end
         EX_CLS_MUL: begin
            acc_state   = ST_MUL_WAIT;
            acc_illegal = 1'b0;
         end
`ifdef EX_SCHED_DIV_EN
         EX_CLS_DIV: begin
            acc_state   = ST_DIV_WAIT;
            acc_illegal = 1'b0;
         end
`endif
         default: ;
      endcase
   end

   // counter is loaded at accept so it reaches zero exactly MUL_LAT-1 cycles after mul_start
   ex_lat_counter #(.WIDTH(CW)) u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept & (acc_state == ST_MUL_WAIT)),
      .load_val (MUL_LOAD),
      .dec      ((state == ST_MUL_WAIT) & ~flush),
      .zero     (cnt_zero)
   );

   // main sequencer: flush beats everything, then accept, then per-state completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         alu_ctl     <= '0;
         mul_ctl     <= '0;
         div_ctl     <= '0;
         mul_start   <= 1'b0;
         res_data    <= '0;
         res_rd      <= '0;
         res_illegal <= 1'b0;
      end else begin
         mul_start <= 1'b0;
         if (flush) begin
            state <= ST_IDLE;
         end else if (accept) begin
            state       <= acc_state;
            alu_ctl     <= in_aluctl;
            mul_ctl     <= in_mulctl;
            div_ctl     <= in_divctl;
            res_rd      <= in_rd;
            res_illegal <= acc_illegal;
            res_data    <= '0;
            mul_start   <= (acc_state == ST_MUL_WAIT);
         end else begin
            case (state)
               ST_ALU_EX: begin
                  res_data <= alu_result;
                  state    <= ST_RESP;
               end
               ST_MUL_WAIT: begin
                  if (cnt_zero) begin
                     res_data <= mul_result;
                     state    <= ST_RESP;
                  end
               end
`ifdef EX_SCHED_DIV_EN
               ST_DIV_WAIT: begin
                  if (div_done) begin
                     res_data <= div_result;
                     state    <= ST_RESP;
                  end
               end
`endif
               ST_RESP: begin
                  if (res_ready) begin
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef EX_SCHED_DIV_EN
   // divider start on the first DIV_WAIT cycle; abort when a flush kills DIV_WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_start <= 1'b0;
         div_abort <= 1'b0;
      end else begin
         div_start <= accept & (acc_state == ST_DIV_WAIT);
         div_abort <= flush & (state == ST_DIV_WAIT);
      end
   end
`else
   assign div_start = 1'b0;
   assign div_abort = 1'b0;
   logic div_unused;
   assign div_unused = ^{div_done, div_result};
`endif

   assign res_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

endmodule
